// File: rtl/vending_pkg.sv
// Shared types and helpers for the parametrised vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_e;

    function automatic int sel_w(input int n);
        return $clog2(n);
    endfunction

    function automatic longint price(input int base, input int step,
                                     input int i);
        return longint'(base) + longint'(i) * longint'(step);
    endfunction

endpackage

// File: rtl/vending_fsm_param_if.sv
// Keypad/coin inputs and dispenser/payout outputs of the vending controller.
interface vending_fsm_param_if
    import vending_pkg::*;
#(
    parameter int COIN_W     = 32,
    parameter int NUM_DRINKS = 4
);
    localparam int SEL_W = sel_w(NUM_DRINKS);

    logic                  coin_valid;
    logic [COIN_W-1:0]     coin;
    logic                  sel_valid;
    logic [SEL_W-1:0]      drink_choose;
    logic                  cancel;
    logic [COIN_W-1:0]     total_coin;
    logic [NUM_DRINKS-1:0] avail_mask;
    logic                  busy;
    logic                  vend_valid;
    logic [SEL_W-1:0]      vend_drink;
    logic [COIN_W-1:0]     change;
    logic                  change_valid;
    logic                  coin_reject;
    logic                  sel_reject;

    modport master (
        output coin_valid, coin, sel_valid, drink_choose, cancel,
        input  total_coin, avail_mask, busy, vend_valid, vend_drink,
        input  change, change_valid, coin_reject, sel_reject
    );

    modport slave (
        input  coin_valid, coin, sel_valid, drink_choose, cancel,
        output total_coin, avail_mask, busy, vend_valid, vend_drink,
        output change, change_valid, coin_reject, sel_reject
    );

endinterface

// File: rtl/vending_price_table.sv
// Linear price table: selected-drink lookup, range check, affordability mask.
module vending_price_table
    import vending_pkg::*;
#(
    parameter int COIN_W     = 32,
    parameter int NUM_DRINKS = 4,
    parameter int PRICE_BASE = 10,
    parameter int PRICE_STEP = 5,
    parameter int SEL_W      = 2
) (
    input  logic [COIN_W-1:0]     credit,
    input  logic [SEL_W-1:0]      sel,
    output logic [COIN_W-1:0]     sel_price,
    output logic                  sel_ok,
    output logic [NUM_DRINKS-1:0] avail_mask
);

    logic [COIN_W-1:0] prices [NUM_DRINKS];

    for (genvar i = 0; i < NUM_DRINKS; i++) begin : g_price
        assign prices[i] = COIN_W'(price(PRICE_BASE, PRICE_STEP, i));
        assign avail_mask[i] = (credit >= prices[i]);
    end

    // Indices past the last drink stay out of range and price 0.
    always_comb begin
        sel_price = '0;
        sel_ok    = 1'b0;
        for (int i = 0; i < NUM_DRINKS; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_price = prices[i];
                sel_ok    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vending_fsm_param.sv
// Vending controller: credit accumulation, selection, vend, change and refund.
module vending_fsm_param
    import vending_pkg::*;
#(
    parameter int COIN_W     = 32,
    parameter int NUM_DRINKS = 4,
    parameter int PRICE_BASE = 10,
    parameter int PRICE_STEP = 5,
    parameter int MAX_CREDIT = 100
) (
    input logic               clk,
    input logic               reset,
    vending_fsm_param_if.slave bus
);

    localparam int SEL_W = sel_w(NUM_DRINKS);
    localparam logic [COIN_W:0] MAX_C = (COIN_W + 1)'(MAX_CREDIT);

    state_e             state_q, state_d;
    logic [COIN_W-1:0]  credit_q, credit_d;
    logic               vend_valid_q, vend_valid_d;
    logic [SEL_W-1:0]   vend_drink_q, vend_drink_d;
    logic [COIN_W-1:0]  change_q, change_d;
    logic               change_valid_q, change_valid_d;
    logic               coin_rej_q, coin_rej_d;
    logic               sel_rej_q, sel_rej_d;

    logic [COIN_W-1:0]  sel_price;
    logic               sel_ok;
    logic [COIN_W:0]    sum;
    logic               coin_over;

    vending_price_table #(
        .COIN_W     (COIN_W),
        .NUM_DRINKS (NUM_DRINKS),
        .PRICE_BASE (PRICE_BASE),
        .PRICE_STEP (PRICE_STEP),
        .SEL_W      (SEL_W)
    ) u_price (
        .credit     (credit_q),
        .sel        (bus.drink_choose),
        .sel_price  (sel_price),
        .sel_ok     (sel_ok),
        .avail_mask (bus.avail_mask)
    );

    assign sum       = {1'b0, credit_q} + {1'b0, bus.coin};
    assign coin_over = ({1'b0, bus.coin} > MAX_C);

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        vend_valid_d   = 1'b0;
        vend_drink_d   = '0;
        change_d       = '0;
        change_valid_d = 1'b0;
        coin_rej_d     = 1'b0;
        sel_rej_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.coin_valid) begin
                    if (coin_over) begin
                        coin_rej_d = 1'b1;
                    end else if (bus.coin != '0) begin
                        credit_d = bus.coin;
                        state_d  = S_COLLECT;
                    end
                end
                sel_rej_d = bus.sel_valid;
            end
            S_COLLECT: begin
                if (bus.cancel) begin
                    state_d        = S_CHANGE;
                    change_d       = credit_q;
                    change_valid_d = 1'b1;
                    coin_rej_d     = bus.coin_valid;
                end else if (bus.sel_valid) begin
                    if (sel_ok && credit_q >= sel_price) begin
                        credit_d     = credit_q - sel_price;
                        vend_valid_d = 1'b1;
                        vend_drink_d = bus.drink_choose;
                        state_d      = S_VEND;
                    end else begin
                        sel_rej_d = 1'b1;
                    end
                    coin_rej_d = bus.coin_valid;
                end else if (bus.coin_valid) begin
                    if (sum <= MAX_C) begin
                        credit_d = sum[COIN_W-1:0];
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end
            end
            S_VEND: begin
                state_d        = S_CHANGE;
                change_d       = credit_q;
                change_valid_d = 1'b1;
                coin_rej_d     = bus.coin_valid;
                sel_rej_d      = bus.sel_valid;
            end
            S_CHANGE: begin
                state_d    = S_IDLE;
                credit_d   = '0;
                coin_rej_d = bus.coin_valid;
                sel_rej_d  = bus.sel_valid;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            vend_valid_q   <= 1'b0;
            vend_drink_q   <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            coin_rej_q     <= 1'b0;
            sel_rej_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            vend_valid_q   <= vend_valid_d;
            vend_drink_q   <= vend_drink_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            coin_rej_q     <= coin_rej_d;
            sel_rej_q      <= sel_rej_d;
        end
    end

    assign bus.total_coin   = credit_q;
    assign bus.busy         = (state_q == S_VEND) || (state_q == S_CHANGE);
    assign bus.vend_valid   = vend_valid_q;
    assign bus.vend_drink   = vend_drink_q;
    assign bus.change       = change_q;
    assign bus.change_valid = change_valid_q;
    assign bus.coin_reject  = coin_rej_q;
    assign bus.sel_reject   = sel_rej_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed and random checks of vending_fsm_param against a behavioural model.
module tb_vending_fsm_param;

    localparam int COIN_W = 32;
    localparam int ND     = 4;
    localparam int BASE   = 10;
    localparam int STEP   = 5;
    localparam int MAXC   = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vending_fsm_param_if #(.COIN_W(COIN_W), .NUM_DRINKS(ND)) vif ();

    vending_fsm_param #(
        .COIN_W     (COIN_W),
        .NUM_DRINKS (ND),
        .PRICE_BASE (BASE),
        .PRICE_STEP (STEP),
        .MAX_CREDIT (MAXC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif.slave)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: credit plus what the output side shows this cycle
    // (0 nothing, 1 dispensing, 2 paying out).
    longint m_credit;
    int     m_show;
    longint e_change;
    int     e_drink;
    bit     e_cr, e_sr;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic longint exp_mask();
        longint m = 0;
        for (int i = 0; i < ND; i++)
            if (m_credit >= BASE + i * STEP) m |= (longint'(1) << i);
        return m;
    endfunction

    task automatic model_reset();
        m_credit = 0;
        m_show   = 0;
        e_change = 0;
        e_drink  = 0;
        e_cr     = 0;
        e_sr     = 0;
    endtask

    task automatic model_step(input bit cv, input longint c, input bit sv,
                              input int d, input bit ca);
        int prev = m_show;
        m_show   = 0;
        e_change = 0;
        e_drink  = 0;
        e_cr     = 0;
        e_sr     = 0;
        if (prev == 1) begin
            m_show   = 2;
            e_change = m_credit;
            e_cr     = cv;
            e_sr     = sv;
        end else if (prev == 2) begin
            m_credit = 0;
            e_cr     = cv;
            e_sr     = sv;
        end else if (m_credit == 0) begin
            if (cv && c > MAXC) e_cr = 1;
            else if (cv && c != 0) m_credit = c;
            e_sr = sv;
        end else if (ca) begin
            m_show   = 2;
            e_change = m_credit;
            e_cr     = cv;
        end else if (sv) begin
            if (d < ND && m_credit >= BASE + d * STEP) begin
                m_credit -= BASE + d * STEP;
                m_show   = 1;
                e_drink  = d;
            end else begin
                e_sr = 1;
            end
            e_cr = cv;
        end else if (cv) begin
            if (m_credit + c <= MAXC) m_credit += c;
            else e_cr = 1;
        end
    endtask

    always @(negedge clk) begin
        if (reset && chk_en) begin
            chk("total_coin", vif.total_coin, m_credit);
            chk("avail_mask", vif.avail_mask, exp_mask());
            chk("busy", vif.busy, m_show != 0);
            chk("vend_valid", vif.vend_valid, m_show == 1);
            chk("vend_drink", vif.vend_drink, e_drink);
            chk("change_valid", vif.change_valid, m_show == 2);
            chk("change", vif.change, e_change);
            chk("coin_reject", vif.coin_reject, e_cr);
            chk("sel_reject", vif.sel_reject, e_sr);
        end
    end

    task automatic cycle(input bit cv, input longint c, input bit sv,
                         input int d, input bit ca);
        vif.coin_valid   = cv;
        vif.coin         = COIN_W'(c);
        vif.sel_valid    = sv;
        vif.drink_choose = 2'(d);
        vif.cancel       = ca;
        @(posedge clk);
        model_step(cv, c & 64'hFFFF_FFFF, sv, d, ca);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        reset            = 1'b0;
        vif.coin_valid   = 1'b0;
        vif.coin         = '0;
        vif.sel_valid    = 1'b0;
        vif.drink_choose = '0;
        vif.cancel       = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_total", vif.total_coin, 0);
        chk("rst_vend", vif.vend_valid, 0);
        chk("rst_change_valid", vif.change_valid, 0);
        chk("rst_busy", vif.busy, 0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // 1
        cycle(1, 5, 0, 0, 0);
        cycle(1, 5, 0, 0, 0);
        chk("t1_total", vif.total_coin, 10);
        chk("t1_mask", vif.avail_mask, 4'b0001);
        cycle(0, 0, 1, 0, 0);
        chk("t1_vend", vif.vend_valid, 1);
        chk("t1_drink", vif.vend_drink, 0);
        idle();
        chk("t1_cv", vif.change_valid, 1);
        chk("t1_change", vif.change, 0);
        idle();
        chk("t1_busy", vif.busy, 0);

        // 2
        cycle(1, 10, 0, 0, 0);
        cycle(1, 10, 0, 0, 0);
        cycle(1, 5, 0, 0, 0);
        chk("t2_total", vif.total_coin, 25);
        chk("t2_mask", vif.avail_mask, 4'b1111);
        cycle(0, 0, 1, 1, 0);
        chk("t2_drink", vif.vend_drink, 1);
        idle();
        chk("t2_change", vif.change, 10);
        idle();
        chk("t2_total0", vif.total_coin, 0);

        // 3
        cycle(1, 10, 0, 0, 0);
        cycle(0, 0, 1, 3, 0);
        chk("t3_srej", vif.sel_reject, 1);
        chk("t3_total", vif.total_coin, 10);
        cycle(0, 0, 0, 0, 1);
        chk("t3_change", vif.change, 10);
        chk("t3_novend", vif.vend_valid, 0);
        idle();

        // 4
        cycle(1, 50, 0, 0, 0);
        cycle(1, 45, 0, 0, 0);
        cycle(1, 10, 0, 0, 0);
        chk("t4_crej", vif.coin_reject, 1);
        chk("t4_total95", vif.total_coin, 95);
        cycle(1, 5, 0, 0, 0);
        chk("t4_total100", vif.total_coin, 100);
        cycle(0, 0, 0, 0, 1);
        idle();
        cycle(1, 150, 0, 0, 0);
        chk("t4_idle_rej", vif.coin_reject, 1);
        chk("t4_idle_total", vif.total_coin, 0);

        // 5
        cycle(1, 20, 0, 0, 0);
        cycle(1, 5, 1, 0, 1);
        chk("t5_change", vif.change, 20);
        chk("t5_crej", vif.coin_reject, 1);
        chk("t5_novend", vif.vend_valid, 0);
        idle();
        cycle(1, 20, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 5, 0, 0, 0);
        chk("t5_vend_crej", vif.coin_reject, 1);
        chk("t5_vend_change", vif.change, 10);
        idle();

        // 6
        cycle(1, 10, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("t6_vend", vif.vend_valid, 1);
        vif.sel_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_vend", vif.vend_valid, 0);
        chk("t6_rst_busy", vif.busy, 0);
        chk("t6_rst_total", vif.total_coin, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle();
        chk("t6_no_change", vif.change_valid, 0);

        // random
        for (int n = 0; n < 4000; n++) begin
            longint c;
            case ($urandom_range(0, 6))
                0: c = 0;
                1: c = 5;
                2: c = 10;
                3: c = 25;
                4: c = 50;
                5: c = 150;
                default: c = longint'($urandom);
            endcase
            cycle($urandom_range(0, 9) < 4, c,
                  $urandom_range(0, 9) < 2, $urandom_range(0, ND - 1),
                  $urandom_range(0, 9) < 1);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
